// File: rtl/mux_src_scan8w4.sv
// rtl/mux_src_scan8w4.sv - entry store and prescaled select generator for an 8:1 4-bit mux
//
// Purpose: holds eight 4-bit entries that feed the data inputs of an 8:1 mux
// and a select that steps through them once every PRESCALE enabled cycles.
// Optional double buffering is compiled in with `define MUX_SRC_SHADOW_EN:
// writes then land in a shadow bank that is copied into d when sel wraps 7->0.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   we         - write strobe for one entry
//   waddr      - entry index to write
//   wdata      - 4-bit data to write
//   scan_en    - enables prescaler and select advance
//   d          - eight active entries (mux data inputs)
//   sel        - current select (mux select)
//   tick       - one-cycle pulse aligned with each new sel value
//   frame_done - one-cycle pulse aligned with the sel 7->0 wrap

module mux_src_scan8w4 #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [3:0] wdata,
  input  logic       scan_en,
  output logic [3:0] d [0:7],
  output logic [2:0] sel,
  output logic       tick,
  output logic       frame_done
);

  // 16 bits covers the full legal PRESCALE range and keeps PRESCALE=1 legal
  // (the counter then simply stays at 0).
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre;
  logic        advance;
  logic        wrap;

  assign advance = scan_en && (pre == PRE_LAST);
  assign wrap    = advance && (sel == 3'd7);

`ifdef MUX_SRC_SHADOW_EN
  logic [3:0] shadow [0:7];
`endif

  // tick/frame_done are registered from the same edge that updates sel and d,
  // so all mux-facing outputs change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      sel        <= '0;
      tick       <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        d[i] <= '0;
`ifdef MUX_SRC_SHADOW_EN
        shadow[i] <= '0;
`endif
      end
    end else begin
      tick       <= advance;
      frame_done <= wrap;

      if (scan_en) begin
        if (advance) begin
          pre <= '0;
          sel <= sel + 3'd1;
        end else begin
          pre <= pre + 16'd1;
        end
      end

`ifdef MUX_SRC_SHADOW_EN
      if (we) begin
        shadow[waddr] <= wdata;
      end
      if (wrap) begin
        for (int i = 0; i < 8; i++) begin
          d[i] <= shadow[i];
        end
        // A write landing on the wrap edge goes straight through as well,
        // otherwise it would be one whole frame late.
        if (we) begin
          d[waddr] <= wdata;
        end
      end
`else
      if (we) begin
        d[waddr] <= wdata;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mux_src_scan8w4.sv
// tb/tb_mux_src_scan8w4.sv - self-checking bench for mux_src_scan8w4

module tb_mux_src_scan8w4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [2:0] waddr = '0;
  logic [3:0] wdata = '0;
  logic       scan_en = 1'b0;

  logic [3:0] d4 [0:7];
  logic [2:0] sel4;
  logic       tick4, frame4;
  logic [3:0] d1 [0:7];
  logic [2:0] sel1;
  logic       tick1, frame1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_src_scan8w4 #(.PRESCALE(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .scan_en(scan_en), .d(d4), .sel(sel4), .tick(tick4), .frame_done(frame4)
  );

  mux_src_scan8w4 #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .scan_en(scan_en), .d(d1), .sel(sel1), .tick(tick1), .frame_done(frame1)
  );

  // Reference model: counts enabled cycles since reset; select, tick and
  // frame follow from plain division of that count.
  int         en_cnt;
  logic       mt4, mf4, mt1, mf1;
  logic [3:0] md4 [0:7];
  logic [3:0] md1 [0:7];
`ifdef MUX_SRC_SHADOW_EN
  logic [3:0] msh [0:7];
`endif

  function automatic logic [31:0] pack(input logic [3:0] a [0:7]);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = a[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    en_cnt = 0;
    mt4 = 0; mf4 = 0; mt1 = 0; mf1 = 0;
    for (int i = 0; i < 8; i++) begin
      md4[i] = '0; md1[i] = '0;
`ifdef MUX_SRC_SHADOW_EN
      msh[i] = '0;
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (scan_en) begin
        en_cnt++;
        mt4 = (en_cnt % 4 == 0);
        mf4 = (en_cnt % 32 == 0);
        mt1 = 1'b1;
        mf1 = (en_cnt % 8 == 0);
      end else begin
        mt4 = 0; mf4 = 0; mt1 = 0; mf1 = 0;
      end
`ifdef MUX_SRC_SHADOW_EN
      if (we) msh[waddr] = wdata;
      if (mf4) for (int i = 0; i < 8; i++) md4[i] = msh[i];
      if (mf1) for (int i = 0; i < 8; i++) md1[i] = msh[i];
`else
      if (we) begin
        md4[waddr] = wdata;
        md1[waddr] = wdata;
      end
`endif
    end
    #1;
  endtask

  task automatic do_reset();
    we = 0; waddr = '0; wdata = '0; scan_en = 0;
    rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_sel4"},   32'(sel4),   32'((en_cnt / 4) % 8));
    chk({tag, "_tick4"},  32'(tick4),  32'(mt4));
    chk({tag, "_frame4"}, 32'(frame4), 32'(mf4));
    chk({tag, "_d4"},     pack(d4),    pack(md4));
    chk({tag, "_sel1"},   32'(sel1),   32'(en_cnt % 8));
    chk({tag, "_tick1"},  32'(tick1),  32'(mt1));
    chk({tag, "_frame1"}, 32'(frame1), 32'(mf1));
    chk({tag, "_d1"},     pack(d1),    pack(md1));
  endtask

  typedef struct {
    logic       en;
    logic [2:0] esel;
    logic       etick;
    logic       eframe;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // PRESCALE=4 from reset: pause with prescaler at 2, resume, tick 2 enabled cycles later
    vecs[0] = '{1'b1, 3'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 3'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 3'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 3'd0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 3'd0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 3'd1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 3'd1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 3'd1, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 3'd1, 1'b0, 1'b0};

    model_clear();
    #2;
    chk("rst_sel", 32'(sel4), 32'd0);
    chk("rst_tick", 32'(tick4), 32'd0);
    chk("rst_frame", 32'(frame4), 32'd0);
    chk("rst_d", pack(d4), 32'd0);

    // Table vectors
    do_reset();
    for (int i = 0; i < 10; i++) begin
      scan_en = vecs[i].en;
      step();
      chk($sformatf("vec%0d_sel", i), 32'(sel4), 32'(vecs[i].esel));
      chk($sformatf("vec%0d_tick", i), 32'(tick4), 32'(vecs[i].etick));
      chk($sformatf("vec%0d_frame", i), 32'(frame4), 32'(vecs[i].eframe));
    end

    // Long pause: 10 cycles frozen at prescaler 2, next tick 2 enabled cycles later
    do_reset();
    scan_en = 1;
    step(); step();
    scan_en = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pause_sel", 32'(sel4), 32'd0);
      chk("pause_tick", 32'(tick4), 32'd0);
    end
    scan_en = 1;
    step();
    chk("resume1_tick", 32'(tick4), 32'd0);
    step();
    chk("resume2_tick", 32'(tick4), 32'd1);
    chk("resume2_sel", 32'(sel4), 32'd1);

    // Full frame from reset: tick every 4th cycle, frame_done only at cycle 32
    do_reset();
    scan_en = 1;
    for (int c = 1; c <= 32; c++) begin
      step();
      chk($sformatf("frame_c%0d_tick", c), 32'(tick4), 32'(c % 4 == 0));
      chk($sformatf("frame_c%0d_sel", c), 32'(sel4), 32'((c / 4) % 8));
      chk($sformatf("frame_c%0d_fd", c), 32'(frame4), 32'(c == 32));
      chk($sformatf("p1_c%0d_tick", c), 32'(tick1), 32'd1);
      chk($sformatf("p1_c%0d_sel", c), 32'(sel1), 32'(c % 8));
    end

`ifndef MUX_SRC_SHADOW_EN
    // Direct write
    do_reset();
    we = 1; waddr = 3'd3; wdata = 4'hC;
    step();
    we = 0;
    chk("dwrite_d", pack(d4), 32'h0000_C000);
`else
    // Shadow write at sel=2 becomes visible only on the wrap
    do_reset();
    scan_en = 1;
    repeat (8) step();
    chk("sh_sel2", 32'(sel4), 32'd2);
    we = 1; waddr = 3'd6; wdata = 4'h9;
    step();
    we = 0;
    begin
      int n = 0;
      while (!frame4 && n < 40) begin
        chk("sh_d6_old", 32'(d4[6]), 32'd0);
        step();
        n++;
      end
      chk("sh_wrap_seen", 32'(frame4), 32'd1);
      chk("sh_d6_new", 32'(d4[6]), 32'h9);
    end
    // Collision: write on the wrap edge (enabled cycle 64)
    repeat (31) step();
    we = 1; waddr = 3'd0; wdata = 4'h5;
    step();
    we = 0;
    chk("col_frame", 32'(frame4), 32'd1);
    chk("col_d0", 32'(d4[0]), 32'h5);
    chk("col_sh0", 32'(u_dut.shadow[0]), 32'h5);
    chk("col_d6", 32'(d4[6]), 32'h9);
    // No change to d with scan_en low, whatever is written
    scan_en = 0;
    for (int i = 0; i < 40; i++) begin
      we = 1; waddr = 3'($urandom_range(0, 7)); wdata = 4'($urandom);
      step();
    end
    we = 0;
    chk("sh_frozen_d", pack(d4), pack(md4));
`endif

    // Asynchronous reset mid-scan with sel=5 and d[2]=A
    do_reset();
    scan_en = 1;
    we = 1; waddr = 3'd2; wdata = 4'hA;
    step();
    we = 0;
    repeat (19) step();
    chk("pre_rst_sel", 32'(sel4), 32'd5);
    chk("pre_rst_tick", 32'(tick4), 32'd1);
`ifndef MUX_SRC_SHADOW_EN
    chk("pre_rst_d2", 32'(d4[2]), 32'hA);
`endif
    rst_n = 0;
    #1;
    chk("async_rst_sel", 32'(sel4), 32'd0);
    chk("async_rst_tick", 32'(tick4), 32'd0);
    chk("async_rst_frame", 32'(frame4), 32'd0);
    chk("async_rst_d", pack(d4), 32'd0);
    chk("async_rst_sel1", 32'(sel1), 32'd0);
    chk("async_rst_d1", pack(d1), 32'd0);

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      scan_en = ($urandom_range(0, 3) != 0);
      we      = ($urandom_range(0, 2) == 0);
      waddr   = 3'($urandom_range(0, 7));
      wdata   = 4'($urandom);
      step();
      check_all("rand");
    end
    we = 0; scan_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
